// File: rtl/waffle_mmio_mem_pkg.sv
// Shared definitions for the WAFFLE memory/MMIO subsystem: register offsets
// within the MMIO block and the response record.
package waffle_pkg;
  localparam int IN_OFS  = 0;
  localparam int OUT_OFS = 1;
  localparam int RESP_DW = 32;

  function automatic int pend_ofs(input int n_ch);
    return 2 * n_ch;
  endfunction

  function automatic int en_ofs(input int n_ch);
    return 2 * n_ch + 1;
  endfunction

  typedef struct packed {
    logic               rvalid;
    logic               fault;
    logic [RESP_DW-1:0] rdata;
  } resp_t;
endpackage

// File: rtl/waffle_mmio_mem_if.sv
// CPU-side request/response bus of the WAFFLE memory subsystem.
interface waffle_mmio_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              user;
  logic [ADDR_W-1:0] pbase;
  logic [ADDR_W-1:0] plimit;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              fault;

  modport master (output req, we, addr, wdata, user, pbase, plimit,
                  input  rvalid, rdata, fault);
  modport slave  (input  req, we, addr, wdata, user, pbase, plimit,
                  output rvalid, rdata, fault);
endinterface

// File: rtl/waffle_mmio_mem_gpio_ch.sv
// One GPIO channel: 2-flop input synchroniser, previous-value register for
// rising-edge detection, and the output register.
module waffle_gpio_ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pin,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] in_val,
  output logic [DATA_W-1:0] out_val,
  output logic              rise
);
  logic [DATA_W-1:0] sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      out_val <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      prev  <= sync2;
      if (wr) out_val <= wdata;
    end
  end

  assign in_val = sync2;
  assign rise   = |(sync2 & ~prev);
endmodule

// File: rtl/waffle_mmio_mem.sv
// WAFFLE memory + MMIO: RAM, N_CH GPIO channels with edge interrupts, and
// base/limit protection of user-mode accesses. One request/cycle, 1-cycle latency.
module waffle_mmio_mem
  import waffle_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int RAM_DEPTH = 900,
  parameter int IO_BASE   = 998,
  parameter int N_CH      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  waffle_mmio_mem_if.slave       bus,
  input  logic [N_CH*DATA_W-1:0] gpio_in,
  output logic [N_CH*DATA_W-1:0] gpio_out,
  output logic                   irq
);
  localparam int EA_W   = ADDR_W + 1;
  localparam int IDX_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int N_REG  = 2 * N_CH + 2;
  localparam int OFS_W  = $clog2(N_REG);
  localparam int PEND_W = N_CH + 1;
  localparam logic [EA_W-1:0]  RAM_END = EA_W'(RAM_DEPTH);
  localparam logic [EA_W-1:0]  IO_LO   = EA_W'(IO_BASE);
  localparam logic [EA_W-1:0]  IO_HI   = EA_W'(IO_BASE + N_REG);
  localparam logic [OFS_W-1:0] PEND_A  = OFS_W'(pend_ofs(N_CH));
  localparam logic [OFS_W-1:0] EN_A    = OFS_W'(en_ofs(N_CH));

  logic [EA_W-1:0]             ea;
  logic                        viol, acc, rd_acc, hit_ram, hit_io;
  logic [OFS_W-1:0]            ofs;
  logic [N_CH-1:0]             ch_rise, ch_wr;
  logic [N_CH-1:0][DATA_W-1:0] ch_in, ch_out;
  logic [DATA_W-1:0]           rd_io;
  logic [PEND_W-1:0]           pend_q, en_q, pend_clr, pend_set;
  resp_t                       resp_q;
  logic                        ram_sel_q;
  logic [DATA_W-1:0]           ram_rd_q;
  logic [DATA_W-1:0]           mem [RAM_DEPTH];
  logic                        resp_unused;

  always_comb begin
    ea      = bus.user ? ({1'b0, bus.pbase} + {1'b0, bus.addr}) : {1'b0, bus.addr};
    // a carry out of pbase+addr is a violation just like exceeding the limit
    viol    = bus.user && (ea[ADDR_W] || (ea[ADDR_W-1:0] > bus.plimit));
    acc     = bus.req && rst_n && !viol;
    rd_acc  = acc && !bus.we;
    hit_ram = ea < RAM_END;
    hit_io  = (ea >= IO_LO) && (ea < IO_HI);
    ofs     = OFS_W'(ea - IO_LO);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ch_wr[c] = acc && bus.we && hit_io && (ofs[OFS_W-1:1] == (OFS_W-1)'(c))
                      && (ofs[0] == 1'(OUT_OFS));
    waffle_gpio_ch #(.DATA_W(DATA_W)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin    (gpio_in[c*DATA_W +: DATA_W]),
      .wr     (ch_wr[c]),
      .wdata  (bus.wdata),
      .in_val (ch_in[c]),
      .out_val(ch_out[c]),
      .rise   (ch_rise[c])
    );
  end
  assign gpio_out = ch_out;

  always_comb begin
    rd_io = '0;
    if (ofs == PEND_A) begin
      rd_io = DATA_W'(pend_q);
    end else if (ofs == EN_A) begin
      rd_io = DATA_W'(en_q);
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (ofs[OFS_W-1:1] == (OFS_W-1)'(c))
          rd_io = (ofs[0] == 1'(IN_OFS)) ? ch_in[c] : ch_out[c];
    end
  end

  // hardware sets are OR-ed in after the W1C mask, so a coincident set wins
  assign pend_clr = (acc && bus.we && hit_io && ofs == PEND_A) ? bus.wdata[PEND_W-1:0] : '0;
  assign pend_set = {bus.req && viol, ch_rise};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_q    <= '0;
      ram_sel_q <= 1'b0;
      pend_q    <= '0;
      en_q      <= '0;
      irq       <= 1'b0;
    end else begin
      resp_q.rvalid <= bus.req;
      resp_q.fault  <= bus.req && viol;
      resp_q.rdata  <= (rd_acc && hit_io) ? RESP_DW'(rd_io) : '0;
      ram_sel_q     <= rd_acc && hit_ram;
      pend_q        <= (pend_q & ~pend_clr) | pend_set;
      if (acc && bus.we && hit_io && ofs == EN_A) en_q <= bus.wdata[PEND_W-1:0];
      irq           <= |(pend_q & en_q);
    end
  end

  always_ff @(posedge clk) begin
    if (acc && hit_ram) begin
      ram_rd_q <= mem[IDX_W'(ea)];
      if (bus.we) mem[IDX_W'(ea)] <= bus.wdata;
    end
  end

  // upper bits of the shared response record stay zero for narrow DATA_W
  assign resp_unused = ^resp_q.rdata;
  assign bus.rvalid  = resp_q.rvalid;
  assign bus.fault   = resp_q.fault;
  assign bus.rdata   = ram_sel_q ? ram_rd_q : resp_q.rdata[DATA_W-1:0];
endmodule

// File: tb/tb_waffle_mmio_mem.sv
// Scoreboard bench for waffle_mmio_mem: a behavioural address-map model predicts
// every response; a negedge monitor pops and compares whenever rvalid is seen.
module tb_waffle_mmio_mem;
  localparam int DW = 8, AW = 16, RAM_D = 900, IO_B = 998, NCH = 1;
  localparam int IN_A = IO_B, OUT_A = IO_B + 1, PEND_A = IO_B + 2, EN_A = IO_B + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH*DW-1:0] gpio_in, gpio_out;
  logic irq;

  waffle_mmio_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  waffle_mmio_mem #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(RAM_D), .IO_BASE(IO_B), .N_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       fault;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, n_req = 0;
  logic [7:0] ram_m [RAM_D];
  logic [7:0] out_m, gin_m;
  logic [1:0] pend_m, en_m;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // present one request on the bus and predict its response from the address map
  task automatic drive(input bit w, input int a, input int d,
                       input bit u = 1'b0, input int pb = 0, input int pl = 0);
    exp_t e;
    int ea;
    bit v;
    bus.req = 1'b1; bus.we = w; bus.addr = AW'(a); bus.wdata = DW'(d);
    bus.user = u; bus.pbase = AW'(pb); bus.plimit = AW'(pl);
    if (!rst_n) return;
    ea = u ? pb + a : a;
    v  = u && (ea > 65535 || ea > pl);
    e.id = n_req; n_req++;
    e.fault = v; e.rdata = 8'h00;
    if (v) pend_m[1] = 1'b1;
    else if (ea < RAM_D) begin
      if (w) ram_m[ea] = 8'(d); else e.rdata = ram_m[ea];
    end else if (ea == IN_A) begin
      if (!w) e.rdata = gin_m;
    end else if (ea == OUT_A) begin
      if (w) out_m = 8'(d); else e.rdata = out_m;
    end else if (ea == PEND_A) begin
      if (w) pend_m = pend_m & ~2'(d); else e.rdata = {6'b0, pend_m};
    end else if (ea == EN_A) begin
      if (w) en_m = 2'(d); else e.rdata = {6'b0, en_m};
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got rvalid=1 want no response");
      end else begin
        mon_e = sb.pop_front();
        if (bus.fault !== mon_e.fault || bus.rdata !== mon_e.rdata) begin
          errors++;
          $display("FAIL resp#%0d: got fault=%0b rdata=%02h want fault=%0b rdata=%02h",
                   mon_e.id, bus.fault, bus.rdata, mon_e.fault, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, a, pb, pl, g;
    bit u;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.user = 1'b0; bus.pbase = '0; bus.plimit = '0;
    gpio_in = '0; out_m = 8'h00; gin_m = 8'h00; pend_m = 2'b00; en_m = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;

    for (int i = 0; i < RAM_D; i++) begin
      @(negedge clk); drive(1'b1, i, $urandom_range(0, 255));
    end

    // plain RAM write/read
    @(negedge clk); drive(1'b1, 10, 8'hA5);
    @(negedge clk); drive(1'b0, 10, 0);

    // protection: in-range, over-limit, carry
    @(negedge clk); drive(1'b1, 50, 8'h3C, 1'b1, 100, 150);
    @(negedge clk); drive(1'b1, 51, 8'h77, 1'b1, 100, 150);
    @(negedge clk); drive(1'b1, 16'h0020, 8'h11, 1'b1, 16'hFFF0, 16'hFFFF);
    @(negedge clk); drive(1'b0, 150, 0);
    @(negedge clk); drive(1'b0, 151, 0);
    @(negedge clk); drive(1'b0, PEND_A, 0);
    @(negedge clk); drive(1'b0, 40, 0, 1'b1, 100, 150);

    // LED-compatible output register
    @(negedge clk); drive(1'b1, OUT_A, 8'h81);
    @(negedge clk); chk("gpio_out_led", gpio_out, 8'h81); drive(1'b0, OUT_A, 0);

    // edge interrupt timing
    @(negedge clk); drive(1'b1, PEND_A, 8'hFF);
    @(negedge clk); drive(1'b1, EN_A, 8'h01);
    @(negedge clk); bus.req = 1'b0; gpio_in = 8'h01;
    @(negedge clk); drive(1'b0, PEND_A, 0);
    @(negedge clk); drive(1'b0, PEND_A, 0);
    pend_m[0] = 1'b1; gin_m = 8'h01;
    @(negedge clk); chk("irq_before_edge", irq, 0); drive(1'b0, PEND_A, 0);
    @(negedge clk); chk("irq_rise", irq, 1); drive(1'b1, PEND_A, 8'h01);
    @(negedge clk); chk("irq_hold", irq, 1); bus.req = 1'b0;
    @(negedge clk); chk("irq_fall", irq, 0);

    // W1C coincident with a new edge: the set wins
    gpio_in = 8'h00; gin_m = 8'h00;
    repeat (4) @(negedge clk);
    gpio_in = 8'h01;
    @(negedge clk);
    @(negedge clk); drive(1'b1, PEND_A, 8'h01); pend_m[0] = 1'b1; gin_m = 8'h01;
    @(negedge clk); drive(1'b0, PEND_A, 0);
    @(negedge clk); chk("irq_set_wins", irq, 1); bus.req = 1'b0;

    // unmapped ranges and the read-only input register
    @(negedge clk); drive(1'b0, 950, 0);
    @(negedge clk); drive(1'b1, IN_A, 8'hEE);
    @(negedge clk); drive(1'b0, IN_A, 0);
    @(negedge clk); drive(1'b1, 1005, 8'h12);
    @(negedge clk); drive(1'b0, 1005, 0);
    @(negedge clk); drive(1'b1, 920, 8'h34);
    @(negedge clk); drive(1'b0, 920, 0);

    // random traffic with a fixed, settled input pattern
    @(negedge clk); bus.req = 1'b0; gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    g = $urandom_range(1, 255);
    gpio_in = DW'(g);
    repeat (5) @(negedge clk);
    gin_m = 8'(g); pend_m[0] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      k = $urandom_range(0, 9);
      u = ($urandom_range(0, 3) == 0);
      case (k)
        0, 1, 2, 3, 4, 5: a = $urandom_range(0, RAM_D - 1);
        6, 7:             a = $urandom_range(IN_A, EN_A);
        8:                a = $urandom_range(RAM_D, IO_B - 1);
        default:          a = $urandom_range(EN_A + 1, 4000);
      endcase
      pb = $urandom_range(0, 200);
      pl = $urandom_range(0, 1200);
      if ($urandom_range(0, 15) == 0) pb = $urandom_range(65000, 65535);
      drive(1'($urandom_range(0, 1)), a, $urandom_range(0, 255), u, pb, pl);
    end

    // reset in the middle of a write burst
    @(negedge clk); drive(1'b1, OUT_A, 8'h5A);
    @(negedge clk); drive(1'b1, 200, 8'hC1);
    @(negedge clk); drive(1'b1, 201, 8'hC2);
    @(negedge clk); rst_n = 1'b0; drive(1'b1, 202, 8'hC3);
    out_m = 8'h00; pend_m = 2'b00; en_m = 2'b00;
    @(negedge clk);
    chk("rst_drop_rvalid", bus.rvalid, 0);
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_mid_irq", irq, 0);
    rst_n = 1'b1; drive(1'b1, 203, 8'hC4);
    @(negedge clk); bus.req = 1'b0;
    repeat (5) @(negedge clk);
    pend_m[0] = 1'b1;
    for (int i = 200; i < 204; i++) begin
      @(negedge clk); drive(1'b0, i, 0);
    end
    @(negedge clk); drive(1'b0, OUT_A, 0);
    @(negedge clk); drive(1'b0, EN_A, 0);
    @(negedge clk); drive(1'b0, PEND_A, 0);
    @(negedge clk); bus.req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/waffle_mmio_mem.md
# waffle_mmio_mem

Parametrised memory and memory-mapped I/O subsystem for the WAFFLE CPU, replacing the fixed 8-bit RAM, single switch port and single LED port. It serves one request per cycle with one-cycle read latency. It provides N_CH GPIO channels with input synchronisers and edge-triggered interrupt pending bits. It applies base/limit protection to user-mode accesses and reports violations as a fault response plus a pending interrupt.

## Interface
- DATA_W, 8, data and GPIO width per channel.
- ADDR_W, 16, address width.
- RAM_DEPTH, 900, RAM words at addresses 0..RAM_DEPTH-1; requires RAM_DEPTH <= IO_BASE.
- IO_BASE, 998, first MMIO address.
- N_CH, 1, GPIO channels, 1..DATA_W-1.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  access request this cycle.
- we  in  1  write when req=1.
- addr  in  ADDR_W  logical address.
- wdata  in  DATA_W  write data.
- user  in  1  1 = user mode; protection applies.
- pbase  in  ADDR_W  protection base (CPU PB).
- plimit  in  ADDR_W  protection limit (CPU PL), inclusive.
- rvalid  out  1  response valid, one cycle after req.
- rdata  out  DATA_W  read data.
- fault  out  1  response was a protection fault.
- gpio_in  in  N_CH*DATA_W  asynchronous inputs; channel c is bits [c*DATA_W +: DATA_W].
- gpio_out  out  N_CH*DATA_W  output registers.
- irq  out  1  |(irq_pend & irq_en), registered.

## Operation
- **Effective address.**
  - user=0: ea = addr.
  - user=1: ea = pbase + addr, computed ADDR_W+1 wide.
  - Violation when the carry is set or ea > plimit.
- **Violation handling.**
  - Write suppressed; response rdata=0, fault=1.
  - Sets irq_pend[N_CH].
- **Address map.**
  - 0..RAM_DEPTH-1: RAM.
  - RAM_DEPTH..IO_BASE-1: unmapped. Reads return 0; writes are ignored; no fault.
  - IO_BASE+2c: channel c synchronised input (read-only; writes ignored).
  - IO_BASE+2c+1: channel c output register (read/write).
  - IO_BASE+2N_CH: IRQ_PEND, bits [N_CH:0]. Write-1-to-clear.
  - IO_BASE+2N_CH+1: IRQ_EN, bits [N_CH:0], read/write.
  - Above the MMIO block: unmapped, same rules as the lower unmapped range.
- **GPIO inputs.**
  - Each channel has a 2-flop synchroniser, then a previous-value register.
  - A rising edge on any bit of channel c sets irq_pend[c].
- **Write responses.**
  - rvalid=1, rdata=0, fault as computed.
- **Priorities.**
  - A hardware set and a W1C clear of the same pend bit in the same cycle: set wins.
  - Read and write to the same location in one request: read-before-write (old data returned).

## Timing
- Request sampled on rising clk. rvalid/rdata/fault are valid the next cycle for exactly one cycle.
- No backpressure; a new req is accepted every cycle.
- Write side effects (RAM, gpio_out, pend, en) are visible to a read issued the next cycle.
- GPIO input latency: gpio_in change → visible at the input address 2 cycles later. irq_pend is set 3 cycles after the edge; irq rises 4 cycles after.
- Reset (rst_n=0 at an edge) clears:
  - rvalid, rdata, fault, gpio_out, irq_pend, irq_en, irq;
  - synchronisers and previous-value registers.
- RAM contents are not reset.
- A request in the cycle rst_n=0 is dropped: no write and no response.
- An input held high through reset produces one pend set 3 cycles after release.

## Structure
- Package waffle_pkg holds:
  - the MMIO offsets: IN_OFS=0, OUT_OFS=1, PEND_OFS=2*N_CH, EN_OFS=2*N_CH+1;
  - typedef resp_t {rvalid, fault, rdata}.
- Sub-module waffle_gpio_ch: one channel's synchroniser, edge detect, output register and pend-set pulse. Instantiated N_CH times by generate.
- RAM is inferred in the top block (M10K), with a registered read port.

## Test plan
- **RAM access, no violation.** Reset, then user=0: write 8'hA5 to addr 10, read addr 10 next cycle → rvalid=1, rdata=8'hA5, fault=0.
- **Protection.** user=1, pbase=100, plimit=150:
  - write 8'h3C to addr 50 → RAM[150]=8'h3C.
  - write to addr 51 → fault=1, RAM[151] unchanged, irq_pend[N_CH]=1.
  - With pbase=16'hFFF0 and addr=16'h0020 → carry fault.
- **LED-compatible output.** Write 8'h81 to 999 → gpio_out ch0 = 8'h81 next cycle; read 999 returns 8'h81.
- **Edge interrupt.** irq_en=1 on bit 0; gpio_in ch0 goes 0→1 → pend[0]=1 after 3 cycles, irq=1 after 4.
  - W1C to IRQ_PEND with 8'h01 → irq falls.
  - W1C in the same cycle as a new edge → pend stays 1.
- **Unmapped and read-only.** Read 950 → rdata=0, fault=0; write 998 → ignored.
- **Mid-stream reset.** rst_n low during a back-to-back write burst → no rvalid next cycle; gpio_out=0; RAM writes already completed are retained.
